uart_rx_core: RTL
=================

# uart_rx_core

UART receiver that recovers 8N1 (optionally 8E1) frames from an asynchronous serial line and presents each byte through a single-entry valid/ready holding register. It is the receive-side counterpart of the team's baud-rate generator and transmit path. It derives its own oversampling tick from the system clock, so it has no external baud input. It sits between the board RX pin and the byte-stream consumer, for example a FIFO or command decoder.

## Interface
- CLK_FREQ, 50000000: system clock frequency in Hz.
- BAUD_RATE, 115200: line bit rate.
- OVERSAMPLE, 16: ticks per bit; even, ≥ 4.
- DATA_BITS, 8: payload bits per frame, 5–8.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- rx_i  in  1  serial line, asynchronous to clk, idles high.
- rx_data  out  DATA_BITS  received byte, LSB = first data bit.
- rx_valid  out  1  rx_data holds an unconsumed byte.
- rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- parity_err  out  1  one-cycle pulse: parity mismatch. Constant 0 when parity is compiled out.
- overrun_err  out  1  one-cycle pulse: a completed byte was dropped because the holding register was full.

## Operation
- rx_i passes through a 2-flop synchronizer. All logic uses the synchronized value, rx_s.
- Tick divisor: TDIV = CLK_FREQ / (BAUD_RATE*OVERSAMPLE), integer floor. TDIV ≥ 2 is required. The counter width is $clog2(TDIV). With the defaults, TDIV = 27 and one bit lasts 432 clocks.
- The tick counter is held at 0 in IDLE and restarts from 0 on start detection. A tick fires when the count equals TDIV-1, and the count then wraps to 0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: start is detected when rx_s = 0 and the previous rx_s = 1 (falling edge). Go to START.
  - START: after OVERSAMPLE/2 ticks, sample rx_s. If it is 1, this is a false start: return to IDLE with no output. If it is 0, go to DATA.
  - DATA: sample every OVERSAMPLE ticks. Shift the bit in LSB-first. After DATA_BITS samples, go to PARITY if parity is enabled, otherwise to STOP.
  - PARITY: one sample, compared against even parity of the data. Go to STOP.
  - STOP: one sample, then return to IDLE on the same cycle. The receiver re-arms at mid-stop-bit, so back-to-back frames are received.
- Stop sample = 1 with no parity error: the frame is good and is delivered to the holding register.
- Stop sample = 0: frame_err pulses and the byte is discarded. IDLE then waits for rx_s to go high before the next falling edge can be detected, so a held-low break is one error, not many.
- Parity error: parity_err pulses and the byte is discarded. frame_err may pulse in the same cycle.
- Holding register delivery:
  - rx_valid = 0: load rx_data and set rx_valid.
  - rx_valid = 1 and rx_ready = 1 in the delivery cycle: the old byte is consumed, the new byte loads, and rx_valid stays 1.
  - rx_valid = 1 and rx_ready = 0: overrun_err pulses, the new byte is dropped, and rx_data is unchanged.
- rx_valid clears on rx_valid && rx_ready when no delivery happens in that cycle.

## Timing
- Reset values: FSM = IDLE, counters = 0, rx_data = 0, rx_valid = 0, all error outputs = 0. The synchronizer flops reset to 1 (idle line).
- Line to FSM: 2 clocks of synchronizer latency.
- rx_valid and the error pulses assert on the clock edge following the stop-bit sample tick.
- The error pulses last exactly one clk cycle.
- rx_data is stable whenever rx_valid = 1.
- Reset asserted mid-frame abandons the frame immediately. After release, the receiver waits for a fresh falling edge.

## Configuration
- UART_RX_PARITY_EN defined: each frame carries an even-parity bit after the data bits. The PARITY state is active and parity_err is driven.
- UART_RX_PARITY_EN undefined: the PARITY state is not built, the frame is 8N1, and parity_err is tied to 0.

## Test plan
- Defaults, send 0x55 as 8N1 at 432 clocks/bit -> rx_valid = 1, rx_data = 0x55. Then rx_ready = 1 for 1 cycle -> rx_valid = 0.
- 5-clock low glitch on an idle rx_i -> no rx_valid, no error pulses, FSM back in IDLE.
- Frame 0x3C with the stop bit driven 0 -> frame_err pulses 1 cycle, rx_valid stays 0. Line held low for 10 bit times produces only one frame_err.
- Back-to-back 0xA5 then 0x3C with rx_ready = 0 -> rx_data = 0xA5, one overrun_err pulse. Repeat with rx_ready = 1 during the second delivery -> rx_data = 0x3C, no overrun.
- Assert rst_n = 0 during bit 3 of a frame -> all outputs 0. After release, frame 0x81 -> rx_data = 0x81.
- With UART_RX_PARITY_EN, send 0x07 with parity bit 0 (wrong) -> parity_err pulse, no rx_valid. Send 0x07 with parity bit 1 -> rx_data = 0x07.

Source files
------------

// File: rtl/uart_rx_core.sv
// uart_rx_core
//   UART receiver for 8N1 frames, or 8E1 when UART_RX_PARITY_EN is defined.
//   An internal divider produces OVERSAMPLE ticks per bit from clk. Bits are
//   sampled at mid-bit. Each good byte goes into a single-entry valid/ready
//   holding register.
//
//   Compile-time option:
//     UART_RX_PARITY_EN  - each frame carries an even-parity bit after the
//                          data bits, and parity_err is driven. When it is
//                          undefined, parity_err is tied to 0.
//
//   Ports:
//     clk          system clock, rising edge
//     rst_n        asynchronous active-low reset
//     rx_i         serial line (asynchronous to clk, idles high)
//     rx_data      received byte, LSB = first data bit
//     rx_valid     rx_data holds an unconsumed byte
//     rx_ready     consumer accepts rx_data when rx_valid && rx_ready
//     frame_err    one-cycle pulse: stop bit sampled low
//     parity_err   one-cycle pulse: parity mismatch
//     overrun_err  one-cycle pulse: completed byte dropped, holding register full
module uart_rx_core #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err
);

  localparam int TDIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int TW   = (TDIV > 1) ? $clog2(TDIV) : 1;
  localparam int OW   = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t               state;
  logic                 sync1;
  logic                 rx_s;
  logic                 rx_prev;
  logic [TW-1:0]        tick_cnt;
  logic [OW-1:0]        os_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bad;
  logic                 tick;

  // The divider is held at 0 in IDLE, so a tick can only fire inside a frame.
  assign tick = (tick_cnt == TW'(TDIV - 1));

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  // All of these reset to the idle-line level, so reset cannot fake a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rx_i;
      rx_s    <= sync1;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      os_cnt      <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      par_bad     <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
      // Consumer handshake. A delivery in the same cycle overrides this below.
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      if (state == IDLE) begin
        tick_cnt <= '0;
        os_cnt   <= '0;
        bit_cnt  <= '0;
        par_bad  <= 1'b0;
        // A true falling edge is needed. A line held low after a break
        // therefore has to return high before a new frame is accepted.
        if (!rx_s && rx_prev) state <= START;
      end else begin
        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        if (tick) begin
          os_cnt <= os_cnt + 1'b1;
          case (state)
            START: begin
              // Sample at the middle of the start bit. A high level here
              // means the start was a glitch.
              if (os_cnt == OW'(OVERSAMPLE / 2 - 1)) begin
                os_cnt <= '0;
                state  <= rx_s ? IDLE : DATA;
              end
            end
            DATA: begin
              if (os_cnt == OW'(OVERSAMPLE - 1)) begin
                os_cnt  <= '0;
                shift   <= {rx_s, shift[DATA_BITS-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
                if (bit_cnt == BW'(DATA_BITS - 1)) begin
                  bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                  state   <= PARITY;
`else
                  state   <= STOP;
`endif
                end
              end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
              if (os_cnt == OW'(OVERSAMPLE - 1)) begin
                os_cnt  <= '0;
                // Even parity: data ones plus the parity bit must be even.
                par_bad <= rx_s ^ (^shift);
                state   <= STOP;
              end
            end
`endif
            STOP: begin
              if (os_cnt == OW'(OVERSAMPLE - 1)) begin
                // Re-arm at mid-stop-bit so that back-to-back frames are received.
                os_cnt    <= '0;
                state     <= IDLE;
                frame_err <= ~rx_s;
`ifdef UART_RX_PARITY_EN
                parity_err <= par_bad;
`endif
                if (rx_s && !par_bad) begin
                  if (!rx_valid || rx_ready) begin
                    rx_data  <= shift;
                    rx_valid <= 1'b1;
                  end else begin
                    overrun_err <= 1'b1;
                  end
                end
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule
